// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives the PC into a combinational instruction
// memory and buffers fetched words in a small prefetch FIFO toward decode.
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned IMEM_BYTES = 32,
    parameter int unsigned DEPTH      = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_pc,
    input  logic [15:0] imem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_pc,
    output logic        halted
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    // 17 bits so that a full 64 KiB window puts every PC in range.
    localparam logic [16:0] IMEM_LIMIT = 17'(IMEM_BYTES);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    state_e             state_q,  state_d;
    logic               halted_q, halted_d;
    logic [15:0]        pc_q,     pc_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];

    logic   pop;
    logic   push;
    logic   pc_in_range;
    entry_t head;

    assign pc_in_range = ({1'b0, pc_q} < IMEM_LIMIT);
    assign head        = fifo_q[rd_ptr_q];

    assign imem_pc   = pc_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? head.instr : 16'h0000;
    assign out_pc    = out_valid ? head.pc    : 16'h0000;
    assign halted    = halted_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fifo_d   = fifo_q;
        push     = 1'b0;

        if (redirect_valid) begin
            // A pop on this edge still counts as delivered; everything else is dropped.
            state_d  = RUN;
            pc_d     = {redirect_pc[15:1], 1'b0};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (state_q == RUN) begin
                if (!pc_in_range) begin
                    state_d = HALT;
                end else if (count_q != FULL_COUNT) begin
                    push = 1'b1;
                end
            end

            if (push) begin
                fifo_d[wr_ptr_q] = '{pc: pc_q, instr: imem_instr};
                wr_ptr_d         = wr_ptr_q + 1'b1;
                pc_d             = pc_q + 16'd2;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        halted_d = (state_d == HALT);
    end

    // NOTE: every register, including FIFO storage, is cleared on reset so no X ever reaches decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q  <= state_d;
            halted_q <= halted_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected deliveries, a
// negedge monitor pops and compares each handshake.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [15:0] imem_pc;
    logic [15:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [15:0] out_pc;
    logic        halted;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [16];
    logic [31:0] exp_q [$];

    fetch_ctrl #(
        .RESET_PC   (16'h0000),
        .IMEM_BYTES (32),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (imem_pc < 16'd32) imem_instr = rom[imem_pc[4:1]];
        else                  imem_instr = 16'hDEAD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", {out_pc, out_instr}, 32'hFFFF_FFFF);
            end else begin
                check("delivered_pc_instr", {out_pc, out_instr}, exp_q.pop_front());
            end
        end
    end

    task automatic push_range(input int start_pc);
        for (int a = start_pc; a < 32; a += 2) begin
            exp_q.push_back({16'(a), rom[a / 2]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        out_ready      = ready;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (halted) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_halt_reached"}, {31'd0, seen}, 32'd1);
        check({name, "_halt_imem_pc"}, {16'd0, imem_pc}, 32'h0000_0020);
        check({name, "_halt_empty"}, {31'd0, out_valid}, 32'd0);
        check({name, "_scoreboard_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        rom = '{16'h8180, 16'h2CB2, 16'hDC67, 16'hDDD9, 16'hFDB1, 16'hC07B,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        out_ready      = 1'b1;

        #2;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_instr", {16'd0, out_instr}, 32'd0);
        check("reset_out_pc", {16'd0, out_pc}, 32'd0);
        check("reset_imem_pc", {16'd0, imem_pc}, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);

        // Streaming run to end of memory.
        push_range(0);
        apply_reset(1'b1);
        step();
        check("run_first_valid", {31'd0, out_valid}, 32'd1);
        wait_halt("run");

        // Redirect while halted.
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0002;
        push_range(2);
        step();
        redirect_valid = 1'b0;
        check("halt_redirect_cleared", {31'd0, halted}, 32'd0);
        check("halt_redirect_imem_pc", {16'd0, imem_pc}, 32'h0000_0002);
        wait_halt("halt_redirect");

        // Backpressure: two entries buffered, fetch stalls.
        apply_reset(1'b0);
        repeat (3) step();
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_head_instr", {16'd0, out_instr}, 32'h0000_8180);
        check("bp_head_pc", {16'd0, out_pc}, 32'd0);
        check("bp_imem_pc", {16'd0, imem_pc}, 32'h0000_0004);
        push_range(0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_no_gap", {31'd0, out_valid}, 32'd1);
        end
        wait_halt("bp");

        // Redirect with a full FIFO and no pop.
        apply_reset(1'b0);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0009;
        step();
        redirect_valid = 1'b0;
        check("redir_flushed", {31'd0, out_valid}, 32'd0);
        check("redir_imem_pc", {16'd0, imem_pc}, 32'h0000_0008);
        push_range(8);
        out_ready = 1'b1;
        wait_halt("redir");

        // Redirect coinciding with a pop.
        apply_reset(1'b0);
        repeat (3) step();
        exp_q.push_back({16'h0000, 16'h8180});
        push_range(6);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0006;
        step();
        redirect_valid = 1'b0;
        check("redir_pop_flushed", {31'd0, out_valid}, 32'd0);
        wait_halt("redir_pop");

        // Asynchronous reset between edges with two entries buffered.
        apply_reset(1'b0);
        repeat (3) step();
        check("areset_pre_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("areset_out_valid", {31'd0, out_valid}, 32'd0);
        check("areset_out_instr", {16'd0, out_instr}, 32'd0);
        check("areset_out_pc", {16'd0, out_pc}, 32'd0);
        check("areset_imem_pc", {16'd0, imem_pc}, 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
